// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch sequencer states: normal fetch, two-word interrupt vector read,
    // and waiting for the high half of a stack-restored PC.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        INT_LO   = 2'd1,
        INT_HI   = 2'd2,
        POP_WAIT = 2'd3
    } fetch_state_e;

    // Bubble instruction value.
    localparam int unsigned NOP = 0;

    localparam logic [31:0] DEF_RESET_VEC = 32'h20;
    localparam logic [31:0] DEF_INT_VEC   = 32'h0;

    // Per-cycle control request seen by the next-PC mux.
    typedef struct packed {
        logic branch;
        logic flush;
        logic pop_lo;
        logic pop_hi;
        logic stall;
        logic take_int;
    } fetch_ctl_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the fetch unit.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16
) (
    input  fetch_state_e        state,
    input  fetch_ctl_t          ctl,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   branch_addr,
    input  logic [INSTR_W-1:0]  pop_data,
    input  logic [INSTR_W-1:0]  lo_q,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [ADDR_W-1:0]   pc_next
);

    // Priority in RUN: branch > flush > pop > interrupt take > stall > sequential.
    always_comb begin
        pc_next = pc;
        case (state)
            RUN: begin
                if (ctl.branch) begin
                    pc_next = branch_addr;
                end else if (ctl.flush) begin
                    if (!ctl.stall) pc_next = pc + ADDR_W'(1);
                end else if (ctl.pop_lo || ctl.pop_hi) begin
                    if (ctl.pop_lo) pc_next[INSTR_W-1:0]      = pop_data;
                    if (ctl.pop_hi) pc_next[ADDR_W-1:INSTR_W] = pop_data;
                end else if (ctl.take_int) begin
                    pc_next = pc;
                end else if (!ctl.stall) begin
                    pc_next = pc + ADDR_W'(1);
                end
            end
            POP_WAIT: begin
                if (ctl.pop_hi) pc_next[ADDR_W-1:INSTR_W] = pop_data;
            end
            INT_HI: begin
                if (!ctl.stall) pc_next = {imem_rdata, lo_q};
            end
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, branch/flush, stack PC restore,
// and two-word interrupt vector fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                IMEM_AW   = 20,
    parameter int                INSTR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(DEF_INT_VEC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_valid,
    input  logic [ADDR_W-1:0]   branch_addr,
    input  logic                pop_lo_valid,
    input  logic                pop_hi_valid,
    input  logic [INSTR_W-1:0]  pop_data,
    input  logic                interrupt,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   int_ret_pc,
    output logic                int_ack
);

    localparam logic [IMEM_AW-1:0] VEC_LO_A = IMEM_AW'(INT_VEC);
    localparam logic [IMEM_AW-1:0] VEC_HI_A = IMEM_AW'(INT_VEC + ADDR_W'(1));

    fetch_state_e        state_q, state_d;
    fetch_ctl_t          ctl;
    logic                pend_q;
    logic                pend_any;
    logic                bubble;
    logic                hold;
    logic                ack_d;
    logic [INSTR_W-1:0]  lo_q;
    logic [ADDR_W-1:0]   pc_next;

    // A request arriving this cycle may be taken immediately.
    assign pend_any = pend_q | interrupt;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // Next state and per-cycle control decode.
    always_comb begin
        state_d      = state_q;
        ctl          = '0;
        ctl.branch   = branch_valid;
        ctl.flush    = flush;
        ctl.pop_lo   = pop_lo_valid;
        ctl.pop_hi   = pop_hi_valid;
        ctl.stall    = stall;
        bubble       = 1'b0;
        hold         = 1'b0;
        ack_d        = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_valid || flush) begin
                    bubble = 1'b1;
                end else if (pop_lo_valid || pop_hi_valid) begin
                    bubble = 1'b1;
                    if (pop_lo_valid && !pop_hi_valid) state_d = POP_WAIT;
                end else if (pend_any && !stall) begin
                    // The instruction at pc is not executed; it is resumed via int_ret_pc.
                    ctl.take_int = 1'b1;
                    bubble       = 1'b1;
                    state_d      = INT_LO;
                end else if (stall) begin
                    hold = 1'b1;
                end
            end
            INT_LO: begin
                bubble = 1'b1;
                if (!stall) state_d = INT_HI;
            end
            INT_HI: begin
                bubble = 1'b1;
                if (!stall) begin
                    state_d = RUN;
                    ack_d   = 1'b1;
                end
            end
            POP_WAIT: begin
                bubble = 1'b1;
                if (pop_hi_valid) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Read the vector words while in the interrupt states, otherwise follow pc.
    always_comb begin
        case (state_q)
            INT_LO:  imem_addr = VEC_LO_A;
            INT_HI:  imem_addr = VEC_HI_A;
            default: imem_addr = pc[IMEM_AW-1:0];
        endcase
    end

    pc_next_mux #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_pc_next_mux (
        .state       (state_q),
        .ctl         (ctl),
        .pc          (pc),
        .branch_addr (branch_addr),
        .pop_data    (pop_data),
        .lo_q        (lo_q),
        .imem_rdata  (imem_rdata),
        .pc_next     (pc_next)
    );

    // PC, instruction register, interrupt bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_VEC;
            instr       <= INSTR_W'(NOP);
            instr_valid <= 1'b0;
            int_ret_pc  <= '0;
            int_ack     <= 1'b0;
            pend_q      <= 1'b0;
            lo_q        <= '0;
        end else begin
            pc      <= pc_next;
            int_ack <= ack_d;
            pend_q  <= pend_any & ~ctl.take_int;
            if (ctl.take_int) int_ret_pc <= pc;
            if (state_q == INT_LO && !stall) lo_q <= imem_rdata;
            if (bubble) begin
                instr       <= INSTR_W'(NOP);
                instr_valid <= 1'b0;
            end else if (!hold) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for branch/flush/stall
// sequencing plus hand-written interrupt, pop, wrap and reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch_valid;
    logic [31:0] branch_addr;
    logic        pop_lo_valid, pop_hi_valid;
    logic [15:0] pop_data;
    logic        interrupt;
    logic [19:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [31:0] pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [31:0] int_ret_pc;
    logic        int_ack;

    int checks = 0;
    int errors = 0;

    logic [15:0] vec_lo = 16'h0050;
    logic [15:0] vec_hi = 16'h0000;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_valid (branch_valid),
        .branch_addr  (branch_addr),
        .pop_lo_valid (pop_lo_valid),
        .pop_hi_valid (pop_hi_valid),
        .pop_data     (pop_data),
        .interrupt    (interrupt),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .int_ret_pc   (int_ret_pc),
        .int_ack      (int_ack)
    );

    always #5 clk = ~clk;

    // Memory contents: vector words at 0/1, a recognisable pattern elsewhere.
    function automatic logic [15:0] m(input logic [31:0] a);
        logic [19:0] t;
        t = a[19:0];
        if (t == 20'd0)      return vec_lo;
        else if (t == 20'd1) return vec_hi;
        else                 return t[15:0] ^ 16'hA5A5;
    endfunction

    always_comb imem_rdata = m({12'd0, imem_addr});

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] ba,
                        input logic pl, input logic ph, input logic [15:0] pd, input logic irq);
        stall = s; flush = f; branch_valid = b; branch_addr = ba;
        pop_lo_valid = pl; pop_hi_valid = ph; pop_data = pd; interrupt = irq;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 0, 16'h0, 0);
    endtask

    typedef struct {
        logic        s, f, b;
        logic [31:0] ba;
        logic [31:0] e_pc;
        logic [15:0] e_ins;
        logic        e_v;
    } vec_t;

    vec_t tv[12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{0,0,0,32'h0,   32'h21,  m(32'h20), 1};
        tv[1]  = '{0,0,0,32'h0,   32'h22,  m(32'h21), 1};
        tv[2]  = '{0,0,0,32'h0,   32'h23,  m(32'h22), 1};
        tv[3]  = '{0,0,0,32'h0,   32'h24,  m(32'h23), 1};
        tv[4]  = '{0,0,1,32'h100, 32'h100, 16'h0,     0};
        tv[5]  = '{0,0,0,32'h0,   32'h101, m(32'h100),1};
        tv[6]  = '{1,0,0,32'h0,   32'h101, m(32'h100),1};
        tv[7]  = '{0,1,0,32'h0,   32'h102, 16'h0,     0};
        tv[8]  = '{1,1,0,32'h0,   32'h102, 16'h0,     0};
        tv[9]  = '{0,0,0,32'h0,   32'h103, m(32'h102),1};
        tv[10] = '{1,0,1,32'h200, 32'h200, 16'h0,     0};
        tv[11] = '{0,0,0,32'h0,   32'h201, m(32'h200),1};

        // Reset state
        rst = 1'b0;
        idle(); idle();
        chk("rst_pc", pc, 32'h20);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_ret", int_ret_pc, 32'h0);
        chk("rst_ack", {31'h0, int_ack}, 32'h0);
        chk("rst_addr", {12'h0, imem_addr}, 32'h20);
        rst = 1'b1;

        // Sequential, branch, flush, stall table
        for (int i = 0; i < 12; i++) begin
            step(tv[i].s, tv[i].f, tv[i].b, tv[i].ba, 0, 0, 16'h0, 0);
            chk($sformatf("tv%0d_pc", i), pc, tv[i].e_pc);
            chk($sformatf("tv%0d_instr", i), {16'h0, instr}, {16'h0, tv[i].e_ins});
            chk($sformatf("tv%0d_valid", i), {31'h0, instr_valid}, {31'h0, tv[i].e_v});
        end

        // Interrupt at pc 0x30
        step(0, 0, 1, 32'h30, 0, 0, 16'h0, 0);
        chk("br30_pc", pc, 32'h30);
        step(0, 0, 0, 32'h0, 0, 0, 16'h0, 1);
        chk("int_ret", int_ret_pc, 32'h30);
        chk("int_take_pc", pc, 32'h30);
        chk("int_take_v", {31'h0, instr_valid}, 32'h0);
        chk("int_lo_addr", {12'h0, imem_addr}, 32'h0);
        idle();
        chk("int_hi_addr", {12'h0, imem_addr}, 32'h1);
        chk("int_hi_v", {31'h0, instr_valid}, 32'h0);
        chk("int_hi_ack", {31'h0, int_ack}, 32'h0);
        idle();
        chk("int_done_pc", pc, 32'h50);
        chk("int_done_ack", {31'h0, int_ack}, 32'h1);
        chk("int_done_v", {31'h0, instr_valid}, 32'h0);
        idle();
        chk("int_after_pc", pc, 32'h51);
        chk("int_after_instr", {16'h0, instr}, {16'h0, m(32'h50)});
        chk("int_after_ack", {31'h0, int_ack}, 32'h0);

        // Interrupt pulse under stall stays pending
        step(1, 0, 0, 32'h0, 0, 0, 16'h0, 1);
        chk("pend_stall_pc", pc, 32'h51);
        chk("pend_stall_v", {31'h0, instr_valid}, 32'h1);
        idle();
        chk("pend_take_ret", int_ret_pc, 32'h51);
        chk("pend_take_v", {31'h0, instr_valid}, 32'h0);
        idle(); idle();
        chk("pend_done_pc", pc, 32'h50);
        chk("pend_done_ack", {31'h0, int_ack}, 32'h1);

        // Pop low, stall with interrupt in POP_WAIT, pop high
        step(0, 0, 0, 32'h0, 1, 0, 16'h1234, 0);
        chk("poplo_pc", pc, 32'h1234);
        chk("poplo_v", {31'h0, instr_valid}, 32'h0);
        step(1, 0, 0, 32'h0, 0, 0, 16'h0, 1);
        chk("popwait_pc", pc, 32'h1234);
        chk("popwait_v", {31'h0, instr_valid}, 32'h0);
        step(0, 0, 0, 32'h0, 0, 1, 16'h0001, 0);
        chk("pophi_pc", pc, 32'h0001_1234);
        chk("pophi_v", {31'h0, instr_valid}, 32'h0);
        idle();
        chk("popint_ret", int_ret_pc, 32'h0001_1234);
        idle(); idle();
        chk("popint_pc", pc, 32'h50);
        chk("popint_ack", {31'h0, int_ack}, 32'h1);
        idle();
        step(0, 0, 0, 32'h0, 0, 1, 16'h0002, 0);
        chk("hirun_pc", pc, 32'h0002_0051);
        chk("hirun_v", {31'h0, instr_valid}, 32'h0);
        idle();
        chk("hirun_next_pc", pc, 32'h0002_0052);
        chk("hirun_next_instr", {16'h0, instr}, {16'h0, m(32'h0002_0051)});

        // Wrap-around and 3-cycle stall
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 16'h0, 0);
        chk("wrap_br_pc", pc, 32'hFFFF_FFFF);
        idle();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_instr", {16'h0, instr}, {16'h0, m(32'hFFFF_FFFF)});
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h0, 0, 0, 16'h0, 0);
            chk($sformatf("stall%0d_pc", i), pc, 32'h0);
            chk($sformatf("stall%0d_instr", i), {16'h0, instr}, {16'h0, m(32'hFFFF_FFFF)});
        end
        idle();
        chk("unstall_pc", pc, 32'h1);
        chk("unstall_instr", {16'h0, instr}, 32'h0050);

        // Reset while in INT_HI, with a second request pending
        step(0, 0, 0, 32'h0, 0, 0, 16'h0, 1);
        chk("rint_ret", int_ret_pc, 32'h1);
        step(0, 0, 0, 32'h0, 0, 0, 16'h0, 1);
        chk("rint_hi_addr", {12'h0, imem_addr}, 32'h1);
        rst = 1'b0;
        idle();
        chk("rint_pc", pc, 32'h20);
        chk("rint_ack", {31'h0, int_ack}, 32'h0);
        chk("rint_ret0", int_ret_pc, 32'h0);
        rst = 1'b1;
        idle();
        chk("rint_rel_pc", pc, 32'h21);
        chk("rint_rel_v", {31'h0, instr_valid}, 32'h1);
        chk("rint_rel_ack", {31'h0, int_ack}, 32'h0);
        idle();
        chk("rint_nopend_pc", pc, 32'h22);
        chk("rint_nopend_v", {31'h0, instr_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
